// File: rtl/adj_row_scanner.sv
// Row scanner for the adjacency RAM: walks one matrix row, skips empty and
// diagonal entries, and streams each neighbour as a valid/ready beat.
module adj_row_scanner #(
    parameter int MAX = 37,
    parameter int W   = 32
) (
    input  logic         clk_50,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] node,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [W-1:0] count,
    output logic [W-1:0] adj_add,
    input  logic [W-1:0] adj_output,
    output logic [W-1:0] di_add,
    input  logic [W-1:0] di_output,
    output logic         wen_adj,
    output logic         wen_di,
    output logic         nbr_valid,
    input  logic         nbr_ready,
    output logic [W-1:0] nbr_node,
    output logic [W-1:0] nbr_weight,
    output logic [W-1:0] nbr_dir,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CHECK = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [W-1:0] MAX_W    = W'(MAX);
    localparam logic [W-1:0] LAST_COL = W'(MAX - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    state_t       r_state;
    logic         r_busy;
    logic         r_done;
    logic         r_error;
    logic         r_valid;
    logic [W-1:0] r_count;
    logic [W-1:0] r_node;
    logic [W-1:0] r_base;
    logic [W-1:0] r_col;
    logic [W-1:0] r_nbr_node;
    logic [W-1:0] r_nbr_weight;
    logic [W-1:0] r_nbr_dir;

    logic [W-1:0] w_base;
    logic [W-1:0] w_addr;
    logic         w_addr_on;
    logic         w_hit;
    logic         w_last;

    assign w_base    = node * MAX_W;
    assign w_addr    = r_base + r_col;
    assign w_addr_on = (r_state == S_ADDR) || (r_state == S_CHECK) || (r_state == S_EMIT);
    assign w_hit     = (adj_output != '0) && (r_col != r_node);
    assign w_last    = (r_col == LAST_COL);

    // nbr_valid rises on entry to EMIT and falls only on the edge where
    // nbr_ready is high; the payload registers do not change while it is up.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_valid      <= 1'b0;
            r_count      <= '0;
            r_node       <= '0;
            r_base       <= '0;
            r_col        <= '0;
            r_nbr_node   <= '0;
            r_nbr_weight <= '0;
            r_nbr_dir    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_node  <= node;
                        r_col   <= '0;
                        if (node < MAX_W) begin
                            r_base  <= w_base;
                            r_state <= S_ADDR;
                        end else begin
                            r_base  <= '0;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_ADDR: r_state <= S_CHECK;
                S_CHECK: begin
                    if (w_hit) begin
                        r_nbr_node   <= r_col;
                        r_nbr_weight <= adj_output;
                        r_nbr_dir    <= di_output;
                        r_valid      <= 1'b1;
                        r_state      <= S_EMIT;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_col   <= r_col + ONE;
                        r_state <= S_ADDR;
                    end
                end
                S_EMIT: begin
                    if (nbr_ready) begin
                        r_valid <= 1'b0;
                        r_count <= r_count + ONE;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_col   <= r_col + ONE;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign count      = r_count;
    assign adj_add    = w_addr_on ? w_addr : '0;
    assign di_add     = adj_add;
    assign wen_adj    = 1'b0;
    assign wen_di     = 1'b0;
    assign nbr_valid  = r_valid;
    assign nbr_node   = r_nbr_node;
    assign nbr_weight = r_nbr_weight;
    assign nbr_dir    = r_nbr_dir;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_adj_row_scanner.sv
// Bench for adj_row_scanner: behavioural RAM, per-cycle observer and an
// expected-beat queue checked against the beats seen on the handshake.
module tb_adj_row_scanner;

    localparam int MAXN   = 37;
    localparam int W      = 32;
    localparam int NWORDS = MAXN * MAXN;

    logic         clk_50;
    logic         rst_n;
    logic         start;
    logic [W-1:0] node;
    logic         busy, done, error;
    logic [W-1:0] count, adj_add, adj_output, di_add, di_output;
    logic         wen_adj, wen_di, nbr_valid, nbr_ready;
    logic [W-1:0] nbr_node, nbr_weight, nbr_dir;
    logic [2:0]   dbg_state;

    logic [W-1:0] adj_mem [0:NWORDS-1];
    logic [W-1:0] di_mem  [0:NWORDS-1];

    int n_checks;
    int n_fail;
    int cyc;
    logic [3*W-1:0] exp_q[$];
    logic [3*W-1:0] obs_q[$];
    logic [W-1:0]   addr_log [0:4095];
    int             done_cnt;
    int             last_done_cyc;
    logic           last_done_err;
    logic [W-1:0]   last_done_count;
    int             valid_cycles;
    int             proto_viol;
    int             wen_seen;
    int             di_diff;
    logic           prev_stall;
    logic [3*W-1:0] prev_payload;
    logic           obs_valid;
    logic [W-1:0]   obs_adj;
    logic [3*W-1:0] obs_payload;

    adj_row_scanner #(.MAX(MAXN), .W(W)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .node(node),
        .busy(busy), .done(done), .error(error), .count(count),
        .adj_add(adj_add), .adj_output(adj_output),
        .di_add(di_add), .di_output(di_output),
        .wen_adj(wen_adj), .wen_di(wen_di),
        .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
        .nbr_node(nbr_node), .nbr_weight(nbr_weight), .nbr_dir(nbr_dir),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // RAM samples its address on the falling edge
    always @(negedge clk_50) begin
        if (adj_add < NWORDS) adj_output <= adj_mem[int'(adj_add)];
        else                  adj_output <= '0;
        if (di_add < NWORDS)  di_output <= di_mem[int'(di_add)];
        else                  di_output <= '0;
    end

    task automatic ram_init();
        for (int i = 0; i < NWORDS; i++) begin
            adj_mem[i] = '0;
            di_mem[i]  = '0;
        end
        adj_mem[1]  = 3; di_mem[1]  = 3;
        adj_mem[4]  = 1; di_mem[4]  = 4;
        adj_mem[19] = 4; di_mem[19] = 1;
        di_mem[5]   = 7;
        adj_mem[37] = 3; di_mem[37] = 1;
        adj_mem[39] = 2; di_mem[39] = 3;
        adj_mem[50] = 3; di_mem[50] = 4;
        adj_mem[36*37]      = 6; di_mem[36*37]      = 2;
        adj_mem[36*37 + 36] = 9; di_mem[36*37 + 36] = 9;
    endtask

    // one cycle: observe at the falling edge, then step past the rising edge
    task automatic tick();
        @(negedge clk_50);
        obs_valid   = nbr_valid;
        obs_adj     = adj_add;
        obs_payload = {nbr_node, nbr_weight, nbr_dir};
        addr_log[cyc % 4096] = adj_add;
        if (nbr_valid && nbr_ready) obs_q.push_back(obs_payload);
        if (nbr_valid) valid_cycles++;
        if (prev_stall && (!nbr_valid || obs_payload != prev_payload)) proto_viol++;
        prev_stall   = nbr_valid && !nbr_ready;
        prev_payload = obs_payload;
        if (done) begin
            done_cnt++;
            last_done_cyc   = cyc;
            last_done_err   = error;
            last_done_count = count;
        end
        if (wen_adj || wen_di) wen_seen++;
        if (di_add !== adj_add) di_diff++;
        @(posedge clk_50);
        #1;
        cyc++;
    endtask

    task automatic start_scan(input logic [W-1:0] n, output int t0);
        node  = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(input int budget, output logic timed_out);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        timed_out = (done_cnt == d0);
    endtask

    task automatic push_exp(input logic [W-1:0] n, input logic [W-1:0] w, input logic [W-1:0] d);
        exp_q.push_back({n, w, d});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; node = '0; nbr_ready = 1'b1;
        repeat (2) @(posedge clk_50);
        #1;
        n_checks++;
        if ({busy, done, error, nbr_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, error, nbr_valid});
        end
        n_checks++;
        if (count !== '0 || adj_add !== '0 || di_add !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: count=%0d adj_add=%0d di_add=%0d want 0", count, adj_add, di_add);
        end
        n_checks++;
        if ({nbr_node, nbr_weight, nbr_dir} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got %h want 0", {nbr_node, nbr_weight, nbr_dir});
        end
        n_checks++;
        if (dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_node0();
        int t0; logic to; int w0; int dd0; logic [3*W-1:0] e, o;
        exp_q.delete(); obs_q.delete();
        push_exp(1, 3, 3); push_exp(4, 1, 4); push_exp(19, 4, 1);
        w0 = wen_seen; dd0 = di_diff; nbr_ready = 1'b1;
        start_scan(0, t0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL node0_busy: got %b want 1", busy); end
        wait_done(200, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL node0_timeout: no done within 200 cycles"); end
        n_checks++;
        if (last_done_cyc - t0 != 77) begin n_fail++; $display("FAIL node0_done_time: got %0d want 77", last_done_cyc - t0); end
        n_checks++;
        if (last_done_count !== 3 || last_done_err !== 1'b0) begin
            n_fail++; $display("FAIL node0_count: got count=%0d err=%b want 3 0", last_done_count, last_done_err);
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL node0_nbeats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL node0_beat: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                         o[3*W-1:2*W], o[2*W-1:W], o[W-1:0], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
            end
        end
        n_checks++;
        if (wen_seen != w0 || di_diff != dd0) begin n_fail++; $display("FAIL node0_wen_di: wen=%0d di_diff=%0d want 0 0", wen_seen - w0, di_diff - dd0); end
        repeat (3) tick();
        n_checks++;
        if (count !== 3 || busy !== 1'b0) begin n_fail++; $display("FAIL node0_hold: count=%0d busy=%b want 3 0", count, busy); end
    endtask

    task automatic test_node1(input string tag);
        int t0; logic to; logic [3*W-1:0] e, o;
        exp_q.delete(); obs_q.delete();
        push_exp(0, 3, 1); push_exp(2, 2, 3); push_exp(13, 3, 4);
        nbr_ready = 1'b1;
        start_scan(1, t0);
        wait_done(200, to);
        n_checks++;
        if (to || last_done_cyc - t0 != 77) begin n_fail++; $display("FAIL %s_done: timeout=%b time=%0d want 0 77", tag, to, last_done_cyc - t0); end
        n_checks++;
        if (last_done_count !== 3) begin n_fail++; $display("FAIL %s_count: got %0d want 3", tag, last_done_count); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_nbeats: got %0d want %0d", tag, obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s_beat: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", tag,
                         o[3*W-1:2*W], o[2*W-1:W], o[W-1:0], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
            end
        end
        n_checks++;
        if (addr_log[t0 % 4096] !== 37 || addr_log[(t0 + 3) % 4096] !== 38 || addr_log[(t0 + 4) % 4096] !== 38) begin
            n_fail++;
            $display("FAIL %s_addr_start: got %0d %0d %0d want 37 38 38", tag,
                     addr_log[t0 % 4096], addr_log[(t0 + 3) % 4096], addr_log[(t0 + 4) % 4096]);
        end
        n_checks++;
        if (addr_log[(t0 + 75) % 4096] !== 73 || addr_log[(t0 + 76) % 4096] !== 73 || addr_log[(t0 + 77) % 4096] !== 0) begin
            n_fail++;
            $display("FAIL %s_addr_end: got %0d %0d %0d want 73 73 0", tag,
                     addr_log[(t0 + 75) % 4096], addr_log[(t0 + 76) % 4096], addr_log[(t0 + 77) % 4096]);
        end
    endtask

    task automatic test_diagonal();
        adj_mem[38] = 5; di_mem[38] = 2;
        test_node1("diag");
        adj_mem[38] = 0; di_mem[38] = 0;
    endtask

    task automatic test_last_row();
        int t0; logic to; logic [3*W-1:0] o;
        exp_q.delete(); obs_q.delete();
        push_exp(0, 6, 2);
        start_scan(36, t0);
        wait_done(200, to);
        n_checks++;
        if (to || last_done_cyc - t0 != 75 || last_done_count !== 1) begin
            n_fail++; $display("FAIL row36_done: timeout=%b time=%0d count=%0d want 0 75 1", to, last_done_cyc - t0, last_done_count);
        end
        n_checks++;
        o = (obs_q.size() == 1) ? obs_q.pop_front() : '1;
        if (o !== exp_q.pop_front()) begin n_fail++; $display("FAIL row36_beat: got %h want (0,6,2)", o); end
    endtask

    task automatic test_backpressure();
        int t0; int d0; int k; int stall; int first_x; int p0; logic [3*W-1:0] e, o;
        exp_q.delete(); obs_q.delete();
        push_exp(1, 3, 3); push_exp(4, 1, 4); push_exp(19, 4, 1);
        nbr_ready = 1'b0; stall = 0; first_x = -1; p0 = proto_viol;
        d0 = done_cnt;
        start_scan(0, t0);
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            tick();
            k++;
            if (obs_q.size() == 1 && first_x < 0) first_x = cyc - 1 - t0;
            if (obs_valid && stall < 10) begin
                n_checks++;
                if (obs_adj !== 1 || obs_payload !== {32'd1, 32'd3, 32'd3}) begin
                    n_fail++; $display("FAIL bp_frozen: adj_add=%0d payload=%h want 1 (1,3,3)", obs_adj, obs_payload);
                end
                stall++;
                if (stall == 10) nbr_ready = 1'b1;
            end
        end
        n_checks++;
        if (done_cnt == d0 || last_done_cyc - t0 != 87) begin n_fail++; $display("FAIL bp_done_time: got %0d want 87", last_done_cyc - t0); end
        n_checks++;
        if (first_x != 14 || stall != 10) begin n_fail++; $display("FAIL bp_first_xfer: cycle=%0d stalls=%0d want 14 10", first_x, stall); end
        n_checks++;
        if (proto_viol != p0 || last_done_count !== 3) begin n_fail++; $display("FAIL bp_proto: viol=%0d count=%0d want 0 3", proto_viol - p0, last_done_count); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL bp_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_random_ready();
        int t0; int d0; int k; int stalls; int p0; logic [3*W-1:0] e, o;
        exp_q.delete(); obs_q.delete();
        push_exp(1, 3, 3); push_exp(4, 1, 4); push_exp(19, 4, 1);
        p0 = proto_viol; stalls = 0; d0 = done_cnt;
        nbr_ready = 1'($urandom_range(0, 1));
        start_scan(0, t0);
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            tick();
            k++;
            if (prev_stall) stalls++;
            nbr_ready = 1'($urandom_range(0, 1));
        end
        nbr_ready = 1'b1;
        n_checks++;
        if (done_cnt == d0 || last_done_cyc - t0 != 77 + stalls) begin
            n_fail++; $display("FAIL rnd_done_time: got %0d want %0d", last_done_cyc - t0, 77 + stalls);
        end
        n_checks++;
        if (proto_viol != p0 || last_done_count !== 3 || obs_q.size() != 3) begin
            n_fail++; $display("FAIL rnd_proto: viol=%0d count=%0d beats=%0d want 0 3 3", proto_viol - p0, last_done_count, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rnd_beat: got %h want %h", o, e); end
        end
    endtask

    task automatic test_error();
        int t0; logic to; int v0;
        exp_q.delete(); obs_q.delete();
        v0 = valid_cycles;
        start_scan(37, t0);
        wait_done(10, to);
        n_checks++;
        if (to || last_done_cyc != t0) begin n_fail++; $display("FAIL err_done_time: timeout=%b time=%0d want 0 0", to, last_done_cyc - t0); end
        n_checks++;
        if (last_done_err !== 1'b1 || last_done_count !== 0) begin
            n_fail++; $display("FAIL err_flag: err=%b count=%0d want 1 0", last_done_err, last_done_count);
        end
        n_checks++;
        if (valid_cycles != v0 || addr_log[t0 % 4096] !== 0) begin
            n_fail++; $display("FAIL err_quiet: valid cycles=%0d addr=%0d want 0 0", valid_cycles - v0, addr_log[t0 % 4096]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int t0; int d0; int k; logic to;
        d0 = done_cnt; nbr_ready = 1'b1;
        start_scan(0, t0);
        k = 0;
        while (obs_adj !== 10 && k < 100) begin
            tick();
            k++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (k >= 100 || {busy, done, error, nbr_valid} !== 4'b0 || count !== 0 || adj_add !== 0 || di_add !== 0) begin
            n_fail++; $display("FAIL midrst_outputs: k=%0d flags=%b count=%0d adj=%0d want 0", k, {busy, done, error, nbr_valid}, count, adj_add);
        end
        n_checks++;
        if ({nbr_node, nbr_weight, nbr_dir} !== '0) begin n_fail++; $display("FAIL midrst_payload: got %h want 0", {nbr_node, nbr_weight, nbr_dir}); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done pulses want 0", done_cnt - d0); end
        test_node0();
    endtask

    task automatic test_start_while_busy();
        int t0; logic to; logic [3*W-1:0] e, o;
        exp_q.delete(); obs_q.delete();
        push_exp(1, 3, 3); push_exp(4, 1, 4); push_exp(19, 4, 1);
        nbr_ready = 1'b1;
        start_scan(0, t0);
        repeat (5) tick();
        node = 5; start = 1'b1;
        tick();
        start = 1'b0; node = 0;
        wait_done(200, to);
        n_checks++;
        if (to || last_done_cyc - t0 != 77 || last_done_count !== 3) begin
            n_fail++; $display("FAIL busy_start: timeout=%b time=%0d count=%0d want 0 77 3", to, last_done_cyc - t0, last_done_count);
        end
        n_checks++;
        if (obs_q.size() != 3) begin n_fail++; $display("FAIL busy_nbeats: got %0d want 3", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL busy_beat: got %h want %h", o, e); end
        end
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0 || count !== 3) begin n_fail++; $display("FAIL busy_after: busy=%b count=%0d want 0 3", busy, count); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; done_cnt = 0; last_done_cyc = 0;
        last_done_err = 1'b0; last_done_count = '0; valid_cycles = 0; proto_viol = 0;
        wen_seen = 0; di_diff = 0; prev_stall = 1'b0; prev_payload = '0;
        obs_valid = 1'b0; obs_adj = '0; obs_payload = '0;
        for (int i = 0; i < 4096; i++) addr_log[i] = '0;
        ram_init();
        test_reset();
        test_node0();
        test_node1("node1");
        test_backpressure();
        test_diagonal();
        test_last_row();
        test_error();
        test_reset_mid_scan();
        test_start_while_busy();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adj_row_scanner.md
# adj_row_scanner

Neighbour-enumeration stage for the Dijkstra datapath, sitting directly downstream of the shared adjacency/direction RAM. On a start pulse it walks one row of the MAX×MAX adjacency matrix, skips zero and diagonal entries, and streams each neighbour as a (node, weight, direction) beat over a valid/ready handshake to the relaxation logic. It ends each scan with a one-cycle done pulse carrying the neighbour count.

## Interface
- MAX, 37: node count; matrix row stride.
- W, 32: data and address width.

- clk_50  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; sampled only in IDLE.
- node  in  W  row to scan; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at scan end.
- error  out  1  one-cycle pulse, concurrent with done, when node ≥ MAX.
- count  out  W  neighbours accepted in the last scan; held until next start.
- adj_add  out  W  adjacency RAM read address.
- adj_output  in  W  adjacency RAM read data (weight; 0 = no edge).
- di_add  out  W  direction RAM read address; always equals adj_add.
- di_output  in  W  direction RAM read data.
- wen_adj, wen_di  out  1  RAM write enables; constant 0.
- nbr_valid  out  1  neighbour beat valid.
- nbr_ready  in  1  consumer accepts beat.
- nbr_node, nbr_weight, nbr_dir  out  W  beat payload: column index, adj word, di word.

## Operation
- States: IDLE, ADDR, CHECK, EMIT, DONE.
- IDLE: on start with node < MAX, base ← node*MAX (low W bits), col ← 0, count ← 0, go to ADDR. With node ≥ MAX, go to DONE with error flagged; no RAM address other than the idle value is presented.
- adj_add = di_add = base + col (combinational from registers); 0 in IDLE/DONE.
- ADDR: address stable for the full cycle; the RAM samples it on the falling edge. Always go to CHECK.
- CHECK: adj_output/di_output are valid. If adj_output ≠ 0 and col ≠ node: latch col, adj_output, di_output into the payload registers and go to EMIT. Otherwise advance.
- EMIT: nbr_valid = 1 and payload held stable. On nbr_ready, count += 1 and advance. nbr_valid never drops without a transfer.
- Advance: if col = MAX-1, go to DONE; else col += 1 and go to ADDR.
- DONE: done = 1 (plus error if flagged) for exactly one cycle, then IDLE.
- start while busy: ignored, with no effect on node, count, or state.
- Diagonal entries (col = node) are skipped regardless of stored value.

## Timing
- Reset (async assert): state IDLE; busy, done, error, nbr_valid = 0; count, adj_add, di_add, payload = 0. Reset mid-scan abandons the scan with no done pulse.
- Start is accepted at posedge T0; busy is high from T0.
- A skipped column costs 2 cycles. An emitted column costs 3 cycles plus any cycles with nbr_ready low.
- Scan length with nbr_ready tied high: 2·MAX + k cycles for k neighbours. DONE follows in the next cycle.
- Error path: DONE in the cycle after T0; count = 0.
- nbr_ready is sampled only in EMIT; ready high with valid low has no effect.
- count updates on the accepting edge and is final when done is high.

## Test plan
- RAM model loaded with the standard init; node=0, ready=1 -> beats (1,3,3), (4,1,4), (19,4,1) in order; done high in the cycle after posedge 77 past T0; count=3; wen_* never 1.
- node=1, ready=1 -> beats (0,3,1), (2,2,3), (13,3,4); count=3. adj_add sweeps 37..73, each value held for 2 consecutive cycles on skipped columns.
- node=0, ready low for 10 cycles on the first beat -> nbr_valid, payload and adj_add=1 frozen for all 10 cycles; the first transfer happens on the 11th cycle; done is 10 cycles later than in the first scenario.
- Preload adj[38]=5 and start with node=1 -> no beat with nbr_node=1; count=3.
- node=37 -> error and done high together in the cycle after T0; count=0; nbr_valid never asserted.
- Drop rst_n at col=10 of a node=0 scan; then start with node=0 -> all outputs 0 immediately and no done pulse from the abandoned scan; the new scan produces the full 3-beat sequence.
- Pulse start with node=5 while busy -> ignored; the running scan's beats and count are unchanged.
